sample_tx_buf: RTL and testbench

//  Output-side transmitter for DSP chains: accepts valid-only samples (no backpressure, e.g. from
//  the resampler/round stage) and drives them onto an AXI-Stream master with tready flow control.

---
 rtl/sample_buf_pkg.sv | 11 +
 rtl/axis_if.sv | 14 +
 rtl/sample_buf_mem.sv | 22 ++
 rtl/sample_tx_buf.sv | 132 +++++++++++++
 tb/tb_sample_tx_buf.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/sample_buf_pkg.sv
// Shared types and helpers for the sample transmit buffer.
package sample_buf_pkg;

    typedef enum logic {FILL, STREAM} tx_state_e;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream interface: tvalid/tready/tdata with master and slave views.
interface axis_if #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic clk_i,
    input logic rst_i
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/sample_buf_mem.sv
// Beat storage for the transmit buffer: synchronous write, asynchronous read.
module sample_buf_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sample_tx_buf.sv
// Valid-only sample input to AXI-Stream master, with prefill gating and sticky overflow/underrun.
// Define SAMPLE_TX_BUF_STAT_EN to add saturating drop/underrun event counters.
module sample_tx_buf
    import sample_buf_pkg::*;
#(
    parameter int unsigned CH_NUM     = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PREFILL    = 8
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             en_i,
    input  logic                             tvalid_i,
    input  logic [CH_NUM*DATA_WIDTH-1:0]     tdata_i,
    axis_if.master                           m_axis,
    input  logic                             clear_i,
    output logic [lvl_width(DEPTH)-1:0]      level_o,
    output logic                             overflow_o,
    output logic                             underrun_o
`ifdef SAMPLE_TX_BUF_STAT_EN
    ,
    output logic [15:0]                      drop_cnt_o,
    output logic [15:0]                      underrun_cnt_o
`endif
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = lvl_width(DEPTH);
    localparam int unsigned W    = CH_NUM * DATA_WIDTH;

    tx_state_e       state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q, level_d;
    logic            overflow_q, underrun_q;
    logic            push, pop, drop, underrun_evt, full;
    logic [W-1:0]    rdata;

    assign full         = (level_q == LvlW'(DEPTH));
    assign pop          = m_axis.tvalid & m_axis.tready;
    assign push         = en_i & tvalid_i & (~full | pop);
    assign drop         = en_i & tvalid_i & full & ~pop;
    assign underrun_evt = pop & ~push & (level_q == LvlW'(1));

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            level_q <= level_d;
        end
    end

    sample_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (tdata_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= FILL;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (level_d >= LvlW'(PREFILL)) state_d = STREAM;
            STREAM:  if (underrun_evt)               state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // tvalid only drops via a pop (or reset), so the presented beat stays stable.
    always_comb begin
        m_axis.tvalid = (state_q == STREAM) && (level_q != '0);
        m_axis.tdata  = rdata;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (clear_i)   overflow_q <= 1'b0;
            else if (drop) overflow_q <= 1'b1;
            if (clear_i)           underrun_q <= 1'b0;
            else if (underrun_evt) underrun_q <= 1'b1;
        end
    end

    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign underrun_o = underrun_q;

`ifdef SAMPLE_TX_BUF_STAT_EN
    logic [15:0] drop_cnt_q, underrun_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            drop_cnt_q     <= '0;
            underrun_cnt_q <= '0;
        end else if (clear_i) begin
            drop_cnt_q     <= '0;
            underrun_cnt_q <= '0;
        end else begin
            if (drop && drop_cnt_q != 16'hFFFF)             drop_cnt_q     <= drop_cnt_q + 16'd1;
            if (underrun_evt && underrun_cnt_q != 16'hFFFF) underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign drop_cnt_o     = drop_cnt_q;
    assign underrun_cnt_o = underrun_cnt_q;
`endif
endmodule

// File: tb/tb_sample_tx_buf.sv
// Randomised bench for sample_tx_buf against a queue-based reference model.
module tb_sample_tx_buf;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned PREFILL = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        tvalid = 1'b0;
    logic [31:0] tdata = '0;
    logic        clear = 1'b0;
    logic [4:0]  level;
    logic        overflow, underrun;
`ifdef SAMPLE_TX_BUF_STAT_EN
    logic [15:0] drop_cnt, underrun_cnt;
`endif

    always #5 clk = ~clk;

    axis_if #(.DATA_WIDTH(32)) axis (.clk_i(clk), .rst_i(~rstn));

    sample_tx_buf #(
        .CH_NUM     (2),
        .DATA_WIDTH (16),
        .DEPTH      (DEPTH),
        .PREFILL    (PREFILL)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .en_i           (en),
        .tvalid_i       (tvalid),
        .tdata_i        (tdata),
        .m_axis         (axis),
        .clear_i        (clear),
        .level_o        (level),
        .overflow_o     (overflow),
        .underrun_o     (underrun)
`ifdef SAMPLE_TX_BUF_STAT_EN
        ,
        .drop_cnt_o     (drop_cnt),
        .underrun_cnt_o (underrun_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the buffer contents as a queue plus streaming/flag state.
    logic [31:0] q[$];
    bit          m_stream;
    bit          m_ovf, m_und;
    logic [15:0] m_drop_cnt, m_und_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_stream   = 0;
        m_ovf      = 0;
        m_und      = 0;
        m_drop_cnt = '0;
        m_und_cnt  = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        en = 1'b0; tvalid = 1'b0; clear = 1'b0; axis.tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    // One cycle: drive inputs, compare outputs against the model, advance the model at the edge.
    task automatic step(input logic e, input logic v, input logic [31:0] d,
                        input logic rdy, input logic clr);
        bit exp_tv, popped, pushed, drop, und;
        en = e; tvalid = v; tdata = d; axis.tready = rdy; clear = clr;
        #1;
        exp_tv = m_stream && (q.size() != 0);
        check_eq("level", 64'(level), 64'(q.size()));
        check_eq("tvalid", 64'(axis.tvalid), 64'(exp_tv));
        if (exp_tv) check_eq("tdata", 64'(axis.tdata), 64'(q[0]));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("underrun", 64'(underrun), 64'(m_und));
`ifdef SAMPLE_TX_BUF_STAT_EN
        check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop_cnt));
        check_eq("underrun_cnt", 64'(underrun_cnt), 64'(m_und_cnt));
`endif
        popped = exp_tv && rdy;
        pushed = 0;
        drop   = 0;
        if (popped) void'(q.pop_front());
        if (e && v) begin
            if (q.size() < DEPTH) begin
                q.push_back(d);
                pushed = 1;
            end else begin
                drop = 1;
            end
        end
        und = popped && !pushed && (q.size() == 0);
        if (und) m_stream = 0;
        if (!m_stream && q.size() >= PREFILL) m_stream = 1;
        m_ovf = clr ? 1'b0 : (m_ovf | drop);
        m_und = clr ? 1'b0 : (m_und | und);
        if (clr) begin
            m_drop_cnt = '0;
            m_und_cnt  = '0;
        end else begin
            if (drop && m_drop_cnt != 16'hFFFF) m_drop_cnt = m_drop_cnt + 16'd1;
            if (und && m_und_cnt != 16'hFFFF)   m_und_cnt  = m_und_cnt + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        axis.tready = 1'b0;
        do_reset();

        // Prefill gating, in-order bit-exact output, then underrun on drain.
        for (int i = 1; i <= 7; i++) step(1, 1, 32'(i), 1, 0);
        check_eq("prefill_tvalid_low", 64'(axis.tvalid), 64'd0);
        step(1, 1, 32'd8, 1, 0);
        check_eq("prefill_tvalid_high", 64'(axis.tvalid), 64'd1);
        check_eq("first_beat", 64'(axis.tdata), 64'd1);
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1, 0);
        check_eq("drain_underrun", 64'(underrun), 64'd1);
        check_eq("drain_tvalid", 64'(axis.tvalid), 64'd0);

        // Overflow: 20 pushes into a stalled 16-deep buffer, then drain in order.
        step(0, 0, '0, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 1, 32'h100 + 32'(i), 0, 0);
        check_eq("ovf_level", 64'(level), 64'(DEPTH));
        check_eq("ovf_flag", 64'(overflow), 64'd1);
`ifdef SAMPLE_TX_BUF_STAT_EN
        check_eq("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
`endif
        for (int i = 0; i < 18; i++) step(0, 0, '0, 1, 0);
        step(0, 0, '0, 0, 1);
        check_eq("clear_flags", 64'({overflow, underrun}), 64'd0);

        // Push and pop together while full: no drop, level holds.
        for (int i = 0; i < 16; i++) step(1, 1, $urandom, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, $urandom, 1, 0);
        check_eq("full_pushpop_level", 64'(level), 64'(DEPTH));
        check_eq("full_pushpop_ovf", 64'(overflow), 64'd0);

        // Stalled output with en toggling keeps tdata stable; then reset mid-stream.
        for (int i = 0; i < 8; i++) step(1'(i), 1, $urandom, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, $urandom, 1, 0);
        do_reset();
        #1;
        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_tvalid", 64'(axis.tvalid), 64'd0);
        for (int i = 0; i < 7; i++) step(1, 1, $urandom, 1, 0);
        check_eq("rst_refill_gated", 64'(axis.tvalid), 64'd0);

        // Random traffic with shifting input/output rates.
        for (int blk = 0; blk < 20; blk++) begin
            int unsigned p_in  = $urandom_range(1, 9);
            int unsigned p_rdy = $urandom_range(1, 9);
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(0, 7) != 0, $urandom_range(0, 9) < p_in, $urandom,
                     $urandom_range(0, 9) < p_rdy, $urandom_range(0, 63) == 0);
            end
            if (blk == 10) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
